// File: rtl/ceespu_wb_arbiter.sv
// ceespu_wb_arbiter: shares the single regfile write port between the ALU
// (requester 0) and the LSU load path (requester 1). Each source owns a
// one-entry holding slot; full slots drain onto the write port under
// round-robin arbitration, with age ordering when both target the same
// register. Values still sitting in a slot are forwarded to read ports A/B.
module ceespu_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 5,
  parameter int DROP_R0 = 0,
  parameter int CNT_W   = 16
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_alu_valid,
  input  logic [SEL_W-1:0]  I_alu_sel,
  input  logic [DATA_W-1:0] I_alu_data,
  output logic              O_alu_ready,
  input  logic              I_mem_valid,
  input  logic [SEL_W-1:0]  I_mem_sel,
  input  logic [DATA_W-1:0] I_mem_data,
  output logic              O_mem_ready,
  output logic              O_we,
  output logic [SEL_W-1:0]  O_selD,
  output logic [DATA_W-1:0] O_dataD,
  input  logic [SEL_W-1:0]  I_selA,
  input  logic [SEL_W-1:0]  I_selB,
  output logic              O_fwdA_hit,
  output logic [DATA_W-1:0] O_fwdA_data,
  output logic              O_fwdB_hit,
  output logic [DATA_W-1:0] O_fwdB_data,
  output logic [CNT_W-1:0]  O_stall_cnt
);

  localparam logic SLOT_EMPTY = 1'b0;
  localparam logic SLOT_FULL  = 1'b1;

  logic              aluState_q, aluState_d;
  logic [SEL_W-1:0]  aluSel_q, aluSel_d;
  logic [DATA_W-1:0] aluData_q, aluData_d;
  logic              memState_q, memState_d;
  logic [SEL_W-1:0]  memSel_q, memSel_d;
  logic [DATA_W-1:0] memData_q, memData_d;
  // 1 when the MEM slot filled before the ALU slot
  logic              memOlder_q, memOlder_d;
  // 1 when the most recent grant went to MEM
  logic              rrLastMem_q, rrLastMem_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

  logic aluFull, memFull;
  logic grantAlu, grantMem;
  logic aluReady, memReady;
  logic aluDrop, memDrop;
  logic aluFill, memFill;
  logic aluStay, memStay;
  logic stallNow;
  logic aluHitA, memHitA, aluHitB, memHitB;

  assign aluFull = (aluState_q == SLOT_FULL);
  assign memFull = (memState_q == SLOT_FULL);

  // Pick which held slot drives the write port: same target -> oldest first, else alternate
  always_comb begin
    grantAlu = 1'b0;
    grantMem = 1'b0;
    if (aluFull && memFull) begin
      if (aluSel_q == memSel_q) begin
        grantAlu = ~memOlder_q;
      end else begin
        grantAlu = rrLastMem_q;
      end
      grantMem = ~grantAlu;
    end else begin
      grantAlu = aluFull;
      grantMem = memFull;
    end
  end

  // A slot can take a new value when empty or when it drains on this same edge
  always_comb begin
    aluReady = ~aluFull | grantAlu;
    memReady = ~memFull | grantMem;
    aluDrop  = (DROP_R0 != 0) && (I_alu_sel == '0);
    memDrop  = (DROP_R0 != 0) && (I_mem_sel == '0);
    aluFill  = I_alu_valid & aluReady & ~aluDrop;
    memFill  = I_mem_valid & memReady & ~memDrop;
    aluStay  = aluFull & ~grantAlu;
    memStay  = memFull & ~grantMem;
    stallNow = (I_alu_valid & ~aluReady) | (I_mem_valid & ~memReady);
  end

  // Next slot contents, age ordering, round-robin pointer and stall counter
  always_comb begin
    aluState_d  = aluFill ? SLOT_FULL : (grantAlu ? SLOT_EMPTY : aluState_q);
    aluSel_d    = aluFill ? I_alu_sel : aluSel_q;
    aluData_d   = aluFill ? I_alu_data : aluData_q;
    memState_d  = memFill ? SLOT_FULL : (grantMem ? SLOT_EMPTY : memState_q);
    memSel_d    = memFill ? I_mem_sel : memSel_q;
    memData_d   = memFill ? I_mem_data : memData_q;

    // The slot still holding an undrained entry is older than anything filled now;
    // if neither survives the edge, a simultaneous fill makes the ALU the older one
    memOlder_d = memOlder_q;
    if (memStay && !aluStay) begin
      memOlder_d = 1'b1;
    end else if (aluStay && !memStay) begin
      memOlder_d = 1'b0;
    end else if (!aluStay && !memStay) begin
      memOlder_d = 1'b0;
    end

    rrLastMem_d = rrLastMem_q;
    if (grantAlu || grantMem) begin
      rrLastMem_d = grantMem;
    end

    stallCnt_d = stallCnt_q;
    if (stallNow && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  // State registers; reset throws away any held entries without writing them
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      aluState_q  <= SLOT_EMPTY;
      aluSel_q    <= '0;
      aluData_q   <= '0;
      memState_q  <= SLOT_EMPTY;
      memSel_q    <= '0;
      memData_q   <= '0;
      memOlder_q  <= 1'b0;
      rrLastMem_q <= 1'b1;
      stallCnt_q  <= '0;
    end else begin
      aluState_q  <= aluState_d;
      aluSel_q    <= aluSel_d;
      aluData_q   <= aluData_d;
      memState_q  <= memState_d;
      memSel_q    <= memSel_d;
      memData_q   <= memData_d;
      memOlder_q  <= memOlder_d;
      rrLastMem_q <= rrLastMem_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  // Write port mirrors the granted slot, all zero when idle
  always_comb begin
    O_we    = 1'b0;
    O_selD  = '0;
    O_dataD = '0;
    if (grantAlu) begin
      O_we    = 1'b1;
      O_selD  = aluSel_q;
      O_dataD = aluData_q;
    end else if (grantMem) begin
      O_we    = 1'b1;
      O_selD  = memSel_q;
      O_dataD = memData_q;
    end
  end

  // Forward held values to the read ports; when both slots match, the younger one wins
  always_comb begin
    aluHitA     = aluFull && (aluSel_q == I_selA);
    memHitA     = memFull && (memSel_q == I_selA);
    aluHitB     = aluFull && (aluSel_q == I_selB);
    memHitB     = memFull && (memSel_q == I_selB);
    O_fwdA_hit  = aluHitA | memHitA;
    O_fwdB_hit  = aluHitB | memHitB;
    O_fwdA_data = '0;
    O_fwdB_data = '0;
    if (aluHitA && memHitA) begin
      O_fwdA_data = memOlder_q ? aluData_q : memData_q;
    end else if (aluHitA) begin
      O_fwdA_data = aluData_q;
    end else if (memHitA) begin
      O_fwdA_data = memData_q;
    end
    if (aluHitB && memHitB) begin
      O_fwdB_data = memOlder_q ? aluData_q : memData_q;
    end else if (aluHitB) begin
      O_fwdB_data = aluData_q;
    end else if (memHitB) begin
      O_fwdB_data = memData_q;
    end
  end

  assign O_alu_ready = aluReady;
  assign O_mem_ready = memReady;
  assign O_stall_cnt = stallCnt_q;

endmodule
